// File: rtl/msb_pkg.sv
// rtl/msb_pkg.sv - shared FSM state, width helpers and shift computation for msb_rescale
package msb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SCALE = 1'b1
  } state_t;

  // Width of msb_index / shift_amt for a given element width
  function automatic int idx_width(input int width);
    return $clog2(width) + 1;
  endfunction

  // Width of the element counter for a given vector length
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Right shift that makes a value with MSB at position m fit in out_width signed bits
  function automatic int calc_shift(input int m, input int out_width);
    int s;
    s = m + 2 - out_width;
    return (s > 0) ? s : 0;
  endfunction

endpackage

// File: rtl/rescale_lane.sv
// rtl/rescale_lane.sv - combinational round-half-up, arithmetic shift and saturate of one element
module rescale_lane #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 8,
  parameter int SW        = 4
) (
  input  logic [WIDTH-1:0]     x,
  input  logic [SW-1:0]        s,
  output logic [OUT_WIDTH-1:0] y
);

  // Bounds of the signed output range, held at the widened working width
  localparam logic signed [WIDTH:0] MAX_V = (WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [WIDTH:0] MIN_V = ~MAX_V;

  logic signed [WIDTH:0] ext;
  logic signed [WIDTH:0] bias;
  logic signed [WIDTH:0] sum;
  logic signed [WIDTH:0] shifted;

  // One extra bit of headroom keeps the rounding add from wrapping at the positive end
  always_comb begin
    ext  = {x[WIDTH-1], x};
    bias = '0;
    if (s != '0) begin
      bias = {{WIDTH{1'b0}}, 1'b1} << (s - SW'(1));
    end
    sum     = ext + bias;
    shifted = sum >>> s;
    if (shifted > MAX_V) begin
      y = MAX_V[OUT_WIDTH-1:0];
    end else if (shifted < MIN_V) begin
      y = MIN_V[OUT_WIDTH-1:0];
    end else begin
      y = shifted[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/msb_rescale.sv
// rtl/msb_rescale.sv - sequential block normalizer: common right shift, round, saturate, one element per cycle
module msb_rescale
  import msb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int OUT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [N-1:0][WIDTH-1:0]         In,
  input  logic [$clog2(WIDTH):0]          msb_index,
  output logic [N-1:0][OUT_WIDTH-1:0]     Out,
  output logic [$clog2(WIDTH):0]          shift_amt,
  output logic                            busy,
  output logic                            done
);

  localparam int IW   = idx_width(WIDTH);
  localparam int CW   = cnt_width(N);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  state_t                    state;
  state_t                    state_next;
  logic [CW-1:0]             idx;
  logic [SELW-1:0]           sel;
  logic [N-1:0][WIDTH-1:0]   x_reg;
  logic [IW-1:0]             m_clamped;
  logic [IW-1:0]             shift_next;
  logic [OUT_WIDTH-1:0]      lane_y;
  logic                      load;
  logic                      step;
  logic                      last;

  assign sel = idx[SELW-1:0];

  // Clamp the reported MSB position to the element width and derive the common shift
  always_comb begin
    m_clamped = msb_index;
    if (msb_index > IW'(WIDTH - 1)) begin
      m_clamped = IW'(WIDTH - 1);
    end
    shift_next = IW'(calc_shift(int'(m_clamped), OUT_WIDTH));
  end

  rescale_lane #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SW        (IW)
  ) u_lane (
    .x (x_reg[sel]),
    .s (shift_amt),
    .y (lane_y)
  );

  // Next-state and control strobes; start is only honoured from IDLE
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = (idx == CW'(N - 1));
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SCALE;
        end
      end
      SCALE: begin
        step = 1'b1;
        if (last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: latch the vector and shift on start, then write one result per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_reg     <= '0;
      Out       <= '0;
      shift_amt <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        x_reg     <= In;
        shift_amt <= shift_next;
        idx       <= '0;
        busy      <= 1'b1;
      end
      if (step) begin
        Out[sel] <= lane_y;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          idx <= idx + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_msb_rescale.sv
// tb/tb_msb_rescale.sv - directed scoreboard bench for msb_rescale
module tb_msb_rescale;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int OW = 8;
  localparam int IW = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [N-1:0][W-1:0]    in_v;
  logic [IW-1:0]          msb;
  logic [N-1:0][OW-1:0]   out_v;
  logic [IW-1:0]          sh;
  logic                   busy;
  logic                   done;

  typedef struct {
    logic [N*OW-1:0] out;
    logic [IW-1:0]   sh;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  msb_rescale #(.WIDTH(W), .N(N), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .In        (in_v),
    .msb_index (msb),
    .Out       (out_v),
    .shift_amt (sh),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack_in(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic logic [N*OW-1:0] pack_out(input int a, input int b, input int c, input int d);
    return {OW'(d), OW'(c), OW'(b), OW'(a)};
  endfunction

  task automatic launch(input logic [N*W-1:0] v, input int m, input logic [N*OW-1:0] e_out, input int e_sh);
    exp_t e;
    @(negedge clk);
    in_v  = v;
    msb   = IW'(m);
    start = 1'b1;
    e.out = e_out;
    e.sh  = IW'(e_sh);
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    check("shift_amt", 64'(sh), 64'(e_sh));
  endtask

  task automatic finish_op(input int inject_at, input logic [N*W-1:0] inj_v);
    int   lat;
    int   extra;
    exp_t e;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == inject_at) begin
        in_v  = inj_v;
        msb   = IW'(3);
        start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (c == 1 && sb.size() > 0) begin
        check("out0_at_t1", 64'(out_v[0]), 64'(sb[0].out[OW-1:0]));
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    check("latency", 64'(lat), 64'(N));
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      check("out_vector", 64'(out_v), 64'(e.out));
      check("shift_hold", 64'(sh), 64'(e.sh));
    end
    @(posedge clk);
    #1;
    check("done_fall", 64'(done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (done) extra++;
    end
    check("extra_done", 64'(extra), 64'(0));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    in_v  = '0;
    msb   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 64'(out_v), 64'(0));
    check("rst_shift", 64'(sh), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    // No shift
    launch(pack_in(100, -50, 3, 0), 6, pack_out(100, -50, 3, 0), 0);
    finish_op(0, '0);

    // Shift with rounding
    launch(pack_in(1000, -1000, 513, -3), 9, pack_out(125, -125, 64, 0), 3);
    finish_op(0, '0);

    // Saturation at both ends
    launch(pack_in(-32768, 200, 255, 1), 7, pack_out(-128, 100, 127, 1), 1);
    finish_op(0, '0);

    // Index clamp, at and beyond WIDTH-1
    launch(pack_in(-1, -2, -3, -4), 15, pack_out(0, 0, 0, 0), 9);
    finish_op(0, '0);
    launch(pack_in(-1, -2, -3, -4), 20, pack_out(0, 0, 0, 0), 9);
    finish_op(0, '0);

    // Start while busy is ignored
    launch(pack_in(1000, -1000, 513, -3), 9, pack_out(125, -125, 64, 0), 3);
    finish_op(2, pack_in(1, 2, 3, 4));

    // Reset in the middle of an operation
    @(negedge clk);
    in_v  = pack_in(-32768, 200, 255, 1);
    msb   = IW'(7);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_out", 64'(out_v), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_shift", 64'(sh), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    launch(pack_in(1000, -1000, 513, -3), 9, pack_out(125, -125, 64, 0), 3);
    finish_op(0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msb_rescale.md
# msb_rescale

Sequential block-normalizer that sits downstream of the attention max/MSB finder. It consumes that block's `msb_index` together with the same signed vector, then right-shifts every element by a common amount so the largest value fits in `OUT_WIDTH` signed bits. Each element is rounded half-up and saturated. One element is processed per cycle, and the applied shift is reported alongside the result for later de-scaling.

## Interface
**Parameters**
- `WIDTH`, 8: input element width, signed.
- `N`, 4: number of elements.
- `OUT_WIDTH`, 8: output element width, signed. Must satisfy `OUT_WIDTH <= WIDTH`.

**Ports**
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a rescale. Sampled only while idle.
- `In` in `[N-1:0]` × `WIDTH` signed: input vector. Captured on the accepted `start` edge.
- `msb_index` in `$clog2(WIDTH)+1`: MSB position of the vector maximum. Captured on the accepted `start` edge.
- `Out` out `[N-1:0]` × `OUT_WIDTH` signed: rescaled vector.
- `shift_amt` out `$clog2(WIDTH)+1`: right-shift applied to the current or last vector.
- `busy` out 1: high from the accepted `start` until `done`.
- `done` out 1: one-cycle pulse when all of `Out` is valid.

## Operation
- **FSM states:** IDLE, SCALE.
- **IDLE, `start`=1:**
  - Latch `In` into an internal register.
  - Clamp `msb_index` to `WIDTH-1`, giving `m`.
  - Register `shift_amt = max(0, m + 2 - OUT_WIDTH)`.
  - Clear the element counter `idx`, set `busy`, go to SCALE.
- **SCALE, each cycle:** write `Out[idx] = sat(round(x[idx] >>> s))`, where `s = shift_amt`, then increment `idx`.
  - `round`: when `s > 0`, add `1 << (s-1)` before the arithmetic shift; when `s = 0`, pass through.
  - Width: the rounding add is done at `WIDTH+1` bits, so it never wraps.
  - `sat`: clamp to the range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- **Last element (`idx = N-1`):** pulse `done`, clear `busy`, return to IDLE. `idx` never wraps past N-1.
- **`start` while in SCALE:** ignored. No restart and no re-latch.
- **Between operations:** `Out` elements keep their old values until overwritten. They are not cleared at `start`.
- **Reset asserted at any time, including mid-SCALE:**
  - State goes to IDLE; `idx`, `busy`, `done`, `shift_amt` go to 0.
  - All `Out` elements and the latched vector go to 0.
  - The partial operation is discarded.
- **Reset values:** `Out`=0, `shift_amt`=0, `busy`=0, `done`=0.

## Timing
- Let T0 be the edge that samples `start`=1 in IDLE.
- `busy` and `shift_amt` are valid after T0.
- Edge T(k+1) writes `Out[k]`, for k=0..N-1.
- `done` rises at edge TN, together with the `Out[N-1]` write, and falls at T(N+1).
- Latency from `start` to `done` is N cycles.
- A new `start` can be accepted at T(N+1), giving a back-to-back throughput of one vector per N+1 cycles.
- `Out[k]` is stable from T(k+1) until that element is rewritten by the next operation.

## Structure
- **Shared package `msb_pkg`:**
  - FSM state enum.
  - Function computing the shift amount from `m`, `WIDTH` and `OUT_WIDTH`.
  - Width localparams: index width `$clog2(WIDTH)+1`, counter width `$clog2(N)+1`.
- **Sub-module `rescale_lane`:** combinational round, shift and saturate for one element, parameterized by `WIDTH` and `OUT_WIDTH`. Instantiated once and fed `x[idx]`.
- **Top level:** FSM, counter, latches and output register.

## Test plan
All scenarios use `WIDTH`=16, `N`=4, `OUT_WIDTH`=8.

1. **No shift.** In={100,-50,3,0}, msb_index=6 → shift_amt=0, Out={100,-50,3,0}, `done` at T4 only.
2. **Shift with rounding.** In={1000,-1000,513,-3}, msb_index=9 → shift_amt=3, Out={125,-125,64,0}.
3. **Saturation.**
   - In={-32768,200,255,1}, msb_index=7 → shift_amt=1, Out={-128,100,127,1}. Both ends saturate; 255 rounds to 128 and clips to 127.
4. **Index clamp.** msb_index=15, In={-1,-2,-3,-4} → shift_amt=9, Out={0,0,0,0}. Repeat with msb_index=20: the clamp gives the identical result.
5. **`start` while busy.** Pulse `start` at T2 with a new In → ignored; results match the first vector and exactly one `done` is seen.
6. **Reset mid-operation.** Drop `reset` at T2 → `Out`, `busy`, `done`, `shift_amt` all 0 immediately. After release, a new `start` completes normally with latency N.
